// File: rtl/ppi_pkg.sv
// Shared definitions for the mode-0/mode-1 parallel port block: control-word
// field positions, port-C handshake bit positions, register addresses and
// the per-group mode decode.
package ppi_pkg;

    // Control word fields (valid when CW_FLAG is set)
    localparam int CW_FLAG    = 7;
    localparam int CW_AMODE_H = 6;
    localparam int CW_AMODE_L = 5;
    localparam int CW_A_DIR   = 4;
    localparam int CW_PCH_DIR = 3;
    localparam int CW_BMODE   = 2;
    localparam int CW_B_DIR   = 1;
    localparam int CW_PCL_DIR = 0;

    // Port C handshake positions; INTE shadows the STB#/ACK# pin position
    localparam int PC_INTR_A  = 3;
    localparam int PC_STB_A   = 4;   // also INTE_A for input mode
    localparam int PC_IBF_A   = 5;
    localparam int PC_ACK_A   = 6;   // also INTE_A for output mode
    localparam int PC_OBF_A   = 7;
    localparam int PC_INTR_B  = 0;
    localparam int PC_IBF_B   = 1;   // OBF_B# when B is an output
    localparam int PC_STB_B   = 2;   // STB_B#/ACK_B#, also INTE_B

    // Register select
    localparam logic [1:0] ADDR_A    = 2'd0;
    localparam logic [1:0] ADDR_B    = 2'd1;
    localparam logic [1:0] ADDR_C    = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    typedef enum logic {
        MODE_0 = 1'b0,
        MODE_1 = 1'b1
    } ppi_mode_e;

    // Group A: 01 is mode 1; 1x falls back to mode 0
    function automatic ppi_mode_e grp_a_mode(input logic [7:0] cw);
        return (cw[CW_AMODE_H:CW_AMODE_L] == 2'b01) ? MODE_1 : MODE_0;
    endfunction

    function automatic ppi_mode_e grp_b_mode(input logic [7:0] cw);
        return cw[CW_BMODE] ? MODE_1 : MODE_0;
    endfunction

endpackage

// File: rtl/ppi_hs_chan.sv
// One strobed handshake channel: synchroniser and edge detector on the
// STB#/ACK# pin, the port data latch, and IBF / OBF# / INTR / INTE state.
// In mode 0 the latch behaves as a plain output latch and the handshake
// pin is ignored.
module ppi_hs_chan #(
    parameter int SYNC_STAGES = 2   // 1..3
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       mode1,
    input  logic       dir_in,
    input  logic       hs_pin,
    input  logic [7:0] pins,
    input  logic       clear,
    input  logic       port_wr,
    input  logic [7:0] wdata,
    input  logic       rd_fall,
    input  logic       rd_rise,
    input  logic       inte_wr,
    input  logic       inte_val,
    output logic [7:0] latch,
    output logic       ibf,
    output logic       obf_n,
    output logic       intr,
    output logic       inte
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hs_prev;
    logic                   hs_s;
    logic                   hs_fall;
    logic                   hs_rise;

    assign hs_s    = sync_q[SYNC_STAGES-1];
    assign hs_fall = mode1 &  hs_prev & ~hs_s;
    assign hs_rise = mode1 & ~hs_prev &  hs_s;

    // Pin synchroniser plus edge-detect flop, idle high
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sync_q  <= '1;
            hs_prev <= 1'b1;
        end else begin
            sync_q[0] <= hs_pin;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            hs_prev <= hs_s;
        end
    end

    // Handshake state; later assignments win, so strobe/ack sets are placed
    // after the bus-side clears and a port write after the ACK# fall.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            latch <= 8'h00;
            ibf   <= 1'b0;
            obf_n <= 1'b1;
            intr  <= 1'b0;
            inte  <= 1'b0;
        end else if (clear) begin
            latch <= 8'h00;
            ibf   <= 1'b0;
            obf_n <= 1'b1;
            intr  <= 1'b0;
            inte  <= 1'b0;
        end else begin
            if (inte_wr) inte <= inte_val;
            if (mode1 && dir_in) begin
                if (rd_fall) intr <= 1'b0;
                if (rd_rise) ibf  <= 1'b0;
                if (hs_fall) begin
                    latch <= pins;      // overwrites an unread byte
                    ibf   <= 1'b1;
                end
                if (hs_rise && inte) intr <= 1'b1;
            end else begin
                if (port_wr) latch <= wdata;
                if (mode1) begin
                    if (hs_fall) obf_n <= 1'b1;
                    if (port_wr) begin
                        obf_n <= 1'b0;
                        intr  <= 1'b0;
                    end
                    if (hs_rise && inte) intr <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ppi_mode1.sv
// Three-port parallel interface with mode-0 I/O and mode-1 strobed
// handshake on ports A and B. Bus strobes are edge-detected against one
// sampled copy, so addr/idata must be stable while a strobe is low.
module ppi_mode1
    import ppi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,      // 1..3
    parameter logic [7:0] RESET_CTRL  = 8'h9B
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [1:0] addr,
    input  logic       we_n,
    input  logic       rd_n,
    input  logic [7:0] idata,
    output logic [7:0] odata,
    input  logic [7:0] ipa,
    input  logic [7:0] ipb,
    input  logic [7:0] ipc,
    output logic [7:0] opa,
    output logic [7:0] opb,
    output logic [7:0] opc
);

    logic [7:0] ctrl;
    logic [7:0] lc;
    logic       we_prev, rd_prev;
    logic       we_fall, rd_fall, rd_rise;
    logic       a_m1, b_m1, a_in, b_in, pch_in, pcl_in;
    logic       ctrl_wr, bsr_wr;
    logic [2:0] bsr_bit;
    logic       inte_a_wr, inte_b_wr;
    logic [7:0] hs_mask;
    logic [7:0] pc_rd;
    logic [7:0] la, lb;
    logic       ibf_a, obf_a_n, intr_a, inte_a;
    logic       ibf_b, obf_b_n, intr_b, inte_b;

    assign a_m1   = (grp_a_mode(ctrl) == MODE_1);
    assign b_m1   = (grp_b_mode(ctrl) == MODE_1);
    assign a_in   = ctrl[CW_A_DIR];
    assign b_in   = ctrl[CW_B_DIR];
    assign pch_in = ctrl[CW_PCH_DIR];
    assign pcl_in = ctrl[CW_PCL_DIR];

    assign we_fall = we_prev & ~we_n;
    assign rd_fall = rd_prev & ~rd_n;
    assign rd_rise = ~rd_prev & rd_n;

    assign ctrl_wr   = we_fall && (addr == ADDR_CTRL) &&  idata[CW_FLAG];
    assign bsr_wr    = we_fall && (addr == ADDR_CTRL) && !idata[CW_FLAG];
    assign bsr_bit   = idata[3:1];
    assign inte_a_wr = bsr_wr && a_m1 &&
                       (bsr_bit == 3'(a_in ? PC_STB_A : PC_ACK_A));
    assign inte_b_wr = bsr_wr && b_m1 && (bsr_bit == 3'(PC_STB_B));

    // Port C bits owned by a mode-1 handshake; BSR cannot reach the latch there
    always_comb begin
        hs_mask = 8'h00;
        if (a_m1) begin
            hs_mask[PC_INTR_A] = 1'b1;
            if (a_in) begin
                hs_mask[PC_STB_A] = 1'b1;
                hs_mask[PC_IBF_A] = 1'b1;
            end else begin
                hs_mask[PC_ACK_A] = 1'b1;
                hs_mask[PC_OBF_A] = 1'b1;
            end
        end
        if (b_m1) begin
            hs_mask[PC_INTR_B] = 1'b1;
            hs_mask[PC_IBF_B]  = 1'b1;
            hs_mask[PC_STB_B]  = 1'b1;
        end
    end

    // Bus strobe samples, idle high
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            we_prev <= 1'b1;
            rd_prev <= 1'b1;
        end else begin
            we_prev <= we_n;
            rd_prev <= rd_n;
        end
    end

    // Control word and port C latch
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ctrl <= RESET_CTRL;
            lc   <= 8'h00;
        end else if (ctrl_wr) begin
            ctrl <= idata;
            lc   <= 8'h00;
        end else if (bsr_wr) begin
            if (!hs_mask[bsr_bit]) lc[bsr_bit] <= idata[0];
        end else if (we_fall && addr == ADDR_C) begin
            lc <= idata;
        end
    end

    ppi_hs_chan #(.SYNC_STAGES(SYNC_STAGES)) u_chan_a (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .mode1    (a_m1),
        .dir_in   (a_in),
        .hs_pin   (a_in ? ipc[PC_STB_A] : ipc[PC_ACK_A]),
        .pins     (ipa),
        .clear    (ctrl_wr),
        .port_wr  (we_fall && addr == ADDR_A),
        .wdata    (idata),
        .rd_fall  (rd_fall && addr == ADDR_A),
        .rd_rise  (rd_rise && addr == ADDR_A),
        .inte_wr  (inte_a_wr),
        .inte_val (idata[0]),
        .latch    (la),
        .ibf      (ibf_a),
        .obf_n    (obf_a_n),
        .intr     (intr_a),
        .inte     (inte_a)
    );

    ppi_hs_chan #(.SYNC_STAGES(SYNC_STAGES)) u_chan_b (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .mode1    (b_m1),
        .dir_in   (b_in),
        .hs_pin   (ipc[PC_STB_B]),
        .pins     (ipb),
        .clear    (ctrl_wr),
        .port_wr  (we_fall && addr == ADDR_B),
        .wdata    (idata),
        .rd_fall  (rd_fall && addr == ADDR_B),
        .rd_rise  (rd_rise && addr == ADDR_B),
        .inte_wr  (inte_b_wr),
        .inte_val (idata[0]),
        .latch    (lb),
        .ibf      (ibf_b),
        .obf_n    (obf_b_n),
        .intr     (intr_b),
        .inte     (inte_b)
    );

    // Port C pin drive: mode-0 latch/input rules, then handshake overrides
    always_comb begin
        opc = {pch_in ? 4'hF : lc[7:4], pcl_in ? 4'hF : lc[3:0]};
        if (a_m1) begin
            opc[PC_INTR_A] = intr_a;
            if (a_in) begin
                opc[PC_STB_A] = 1'b1;
                opc[PC_IBF_A] = ibf_a;
            end else begin
                opc[PC_ACK_A] = 1'b1;
                opc[PC_OBF_A] = obf_a_n;
            end
        end
        if (b_m1) begin
            opc[PC_STB_B]  = 1'b1;
            opc[PC_IBF_B]  = b_in ? ibf_b : obf_b_n;
            opc[PC_INTR_B] = intr_b;
        end
    end

    // Port C read view: status replaces the handshake positions
    always_comb begin
        pc_rd = {pch_in ? ipc[7:4] : lc[7:4], pcl_in ? ipc[3:0] : lc[3:0]};
        if (a_m1) begin
            pc_rd[PC_INTR_A] = intr_a;
            if (a_in) begin
                pc_rd[PC_STB_A] = inte_a;
                pc_rd[PC_IBF_A] = ibf_a;
            end else begin
                pc_rd[PC_ACK_A] = inte_a;
                pc_rd[PC_OBF_A] = obf_a_n;
            end
        end
        if (b_m1) begin
            pc_rd[PC_STB_B]  = inte_b;
            pc_rd[PC_IBF_B]  = b_in ? ibf_b : obf_b_n;
            pc_rd[PC_INTR_B] = intr_b;
        end
    end

    // Zero-latency read mux; mode-1 input ports return the strobed latch
    always_comb begin
        odata = 8'h00;
        case (addr)
            ADDR_A:  odata = (a_in && !a_m1) ? ipa : la;
            ADDR_B:  odata = (b_in && !b_m1) ? ipb : lb;
            ADDR_C:  odata = pc_rd;
            default: odata = 8'h00;
        endcase
    end

    assign opa = a_in ? 8'hFF : la;
    assign opb = b_in ? 8'hFF : lb;

endmodule

// File: doc/ppi_mode1.md
PPI_MODE1 -- requirements
Module: ppi_mode1

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth on strobe/ack inputs, legal range 1..3.
REQ-002 SHALL have parameter RESET_CTRL, default 8'h9B: control word loaded at reset (all ports mode-0 input).
REQ-003 clk_sys  in  1  sole clock; all state on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 addr  in  2  register select: 0=A, 1=B, 2=C, 3=control.
REQ-006 we_n  in  1  write strobe, active-low, asynchronous to clk_sys.
REQ-007 rd_n  in  1  read strobe, active-low, used only for handshake side effects.
REQ-008 idata  in  8  write data.
REQ-009 odata  out  8  combinational read data for addr.
REQ-010 ipa/ipb/ipc  in  8 each  pin inputs.
REQ-011 opa/opb/opc  out  8 each  pin outputs; input-configured bits drive 1.

Function
REQ-012 Control word (bit7=1): bit6:5 group-A mode, bit4 A dir, bit3 PCH dir, bit2 group-B mode, bit1 B dir, bit0 PCL dir (1=input); mode 1x is treated as mode 0.
REQ-013 Writes act on the clk_sys cycle in which a we_n falling edge is detected (previous-sample high, current low); one write per edge.
REQ-014 Mode-0 behaviour: output latches on A/B/C; reading an output port returns the latch, reading an input port returns the pins.
REQ-015 Control write with bit7=1 SHALL clear the A/B/C latches, INTE_A/INTE_B, INTR_A/INTR_B and IBF, set OBF# to 1, and load mode.
REQ-016 Control write with bit7=0 (BSR): bit idata[3:1] of the C latch <= idata[0]; when the target is a group's INTE position (A in: PC4, A out: PC6, B: PC2) in mode 1, INTE is written instead; BSR to other mode-1 status positions is ignored.
REQ-017 A mode-1 input: PC4=STB_A# in, PC5=IBF_A out, PC3=INTR_A out.
REQ-018 A mode-1 output: PC7=OBF_A# out, PC6=ACK_A# in, PC3=INTR_A out.
REQ-019 B mode 1: PC2=STB_B#/ACK_B# in, PC1=IBF_B/OBF_B# out, PC0=INTR_B out.
REQ-020 STB/ACK pins pass through SYNC_STAGES flops, then a one-flop edge detector.
REQ-021 Input channel: on detected STB# fall, latch the pin byte and set IBF; on STB# rise, set INTR if INTE=1.
REQ-022 Input channel: on rd_n fall with the port addressed, clear INTR; on rd_n rise, clear IBF.
REQ-023 Output channel: on a port write, OBF#<=0 and INTR<=0; on ACK# fall, OBF#<=1; on ACK# rise, INTR<=1 if INTE=1.
REQ-024 Simultaneous events: set beats clear (STB/ACK over rd), and a port write beats ACK fall (OBF# stays 0).
REQ-025 A STB# fall while IBF=1 SHALL overwrite the latch; IBF stays 1 (no overflow flag).
REQ-026 A port-C read in mode 1 returns the status bits (IBF, OBF#, INTR, INTE) at the handshake positions; other bits follow mode-0 rules.
REQ-027 Latency: status pins change SYNC_STAGES+1 cycles after a pin edge and 1 cycle after a bus-strobe edge; read data is zero-latency.
REQ-028 Addr 3 reads SHALL return 8'h00.

Reset
REQ-029 Reset SHALL load: mode=RESET_CTRL; latches 0; INTE, INTR, IBF 0; OBF# 1; synchronisers and edge detectors at 1 (idle-high); we_n/rd_n samples at 1.
REQ-030 Reset mid-handshake SHALL abandon the transfer, with no pending INTR after release.

Structure
REQ-031 Shared package ppi_pkg SHALL hold the control-word field indices, PC handshake bit indices and the mode enum.
REQ-032 One sub-module, ppi_hs_chan, SHALL implement a single handshake channel (sync, edge detect, IBF/OBF#/INTR/INTE, data latch, direction input); it is instantiated for A and B.

Verification
REQ-033 Reset, then read addr 0/1/2 with pins 8'h5A -> 8'h5A; opa=opb=opc=8'hFF.
REQ-034 Write control 8'hB4 and BSR 8'h09 (INTE_A=1); pulse STB_A# with ipa=8'h3C -> IBF_A=1, then INTR_A=1 at STB rise; read A -> 8'h3C, INTR_A clears on rd fall, IBF_A on rd rise.
REQ-035 Write control 8'hA4, BSR 8'h0D, write A=8'hC3 -> opa=8'hC3 and PC7=0; ACK_A# low -> PC7=1; ACK_A# high -> PC3=1.
REQ-036 Write control 8'h86 (B mode-1 input); STB_B# fall and rd_n rise on port B in the same cycle -> IBF_B remains 1.
REQ-037 Assert reset mid-STB with IBF=1 -> all status cleared, mode=8'h9B, odata for addr 3 = 8'h00.
